// File: rtl/vga_scan_ctrl_if.sv
// Bundle between the raster generator, the colour mapper and the VGA DAC pins.
// The master side is the timing generator; the slave side is the mapper/DAC.
interface vga_scan_ctrl_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       Pix_Tick;
  logic       Frame_Start;
  logic [7:0] Red_In;
  logic [7:0] Green_In;
  logic [7:0] Blue_In;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;

  modport master (
    output DrawX, DrawY, Pix_Tick, Frame_Start,
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
    input  Red_In, Green_In, Blue_In
  );

  modport slave (
    input  DrawX, DrawY, Pix_Tick, Frame_Start,
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
    output Red_In, Green_In, Blue_In
  );
endinterface

// File: rtl/vga_scan_ctrl.sv
// Raster timing generator: scans DrawX/DrawY, takes the mapper's RGB back and
// drives sync/blank delayed so they line up with that RGB at the DAC.
module vga_scan_ctrl #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SW     = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SW     = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int PIPE_DLY = 1
) (
  input  logic            Clk,
  input  logic            Reset_n,
  vga_scan_ctrl_if.master vga
);

  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SW - 1);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SW - 1);

  localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [9:0]       hc;
  logic [9:0]       vc;
  logic             h_last;
  logic             v_last;
  logic             pix_tick;
  logic             frame_start;
  logic             hs_raw;
  logic             vs_raw;
  logic             vis_raw;
  logic             hs_dly;
  logic             vs_dly;
  logic             vis_dly;
  logic [7:0]       r_q;
  logic [7:0]       g_q;
  logic [7:0]       b_q;
  logic             hs_q;
  logic             vs_q;
  logic             blank_n_q;

  // Pixel divider as a down-counter; terminal count at zero is the pixel tick.
  assign tick = (div_cnt == '0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt <= DIV_LOAD;
    end else if (tick) begin
      div_cnt <= DIV_LOAD;
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

  assign h_last = (hc == H_LAST);
  assign v_last = (vc == V_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hc          <= '0;
      vc          <= '0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= tick;
      frame_start <= tick && h_last && v_last;
      if (tick) begin
        if (h_last) begin
          hc <= '0;
          vc <= v_last ? '0 : vc + 10'd1;
        end else begin
          hc <= hc + 10'd1;
        end
      end
    end
  end

  assign hs_raw  = !((hc >= HS_BEG) && (hc <= HS_END));
  assign vs_raw  = !((vc >= VS_BEG) && (vc <= VS_END));
  assign vis_raw = (hc < H_VIS_W) && (vc < V_VIS_W);

  // Sync/blank ride a shift pipe matching the mapper's read latency.
  generate
    if (PIPE_DLY > 0) begin : g_pipe
      logic [2:0] stage [PIPE_DLY];

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          for (int i = 0; i < PIPE_DLY; i++) begin
            stage[i] <= 3'b110;
          end
        end else if (tick) begin
          stage[0] <= {hs_raw, vs_raw, vis_raw};
          for (int i = 1; i < PIPE_DLY; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign {hs_dly, vs_dly, vis_dly} = stage[PIPE_DLY-1];
    end else begin : g_no_pipe
      assign {hs_dly, vs_dly, vis_dly} = {hs_raw, vs_raw, vis_raw};
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else if (tick) begin
      hs_q      <= hs_dly;
      vs_q      <= vs_dly;
      blank_n_q <= vis_dly;
      r_q       <= vis_dly ? vga.Red_In   : 8'h00;
      g_q       <= vis_dly ? vga.Green_In : 8'h00;
      b_q       <= vis_dly ? vga.Blue_In  : 8'h00;
    end
  end

  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.Pix_Tick    = pix_tick;
  assign vga.Frame_Start = frame_start;
  assign vga.VGA_R       = r_q;
  assign vga.VGA_G       = g_q;
  assign vga.VGA_B       = b_q;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK_N = blank_n_q;
  assign vga.VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl on a shrunken raster (30x13) so whole frames fit in a
// short run; a tick-pipelined mapper model feeds RGB back from DrawX/DrawY.
module tb_vga_scan_ctrl;
  localparam int H_VIS = 16, H_FP = 4, H_SW = 6, H_BP = 4;
  localparam int V_VIS = 6,  V_FP = 2, V_SW = 2, V_BP = 3;
  localparam int CLK_DIV = 2, PIPE_DLY = 1;
  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
  localparam int N_VEC = 15;
  localparam int RUN_CLKS = 2 * 780 + 60;

  typedef struct {
    int          x;
    int          y;
    logic        hs;
    logic        vs;
    logic        bn;
    logic [23:0] rgb;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  bit   ff_mode = 1'b0;
  int   checks = 0;
  int   failures = 0;

  vec_t vecs [N_VEC];
  bit   vec_hit [N_VEC];
  vec_t sb [$];
  vec_t cur;
  int   mx, my, n_clk, n_tick;
  int   fs_tick, hs_low, vs_low, vis_cnt;
  bit   line_seen, frame_seen;

  vga_scan_ctrl_if vif ();

  vga_scan_ctrl #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .PIPE_DLY(PIPE_DLY)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .vga(vif)
  );

  always #5 Clk = ~Clk;

  // Mapper model: coordinate history shifted once per pixel.
  logic [9:0] hx [PIPE_DLY+1];
  logic [9:0] hy [PIPE_DLY+1];

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i <= PIPE_DLY; i++) begin
        hx[i] <= '0;
        hy[i] <= '0;
      end
    end else if (vif.Pix_Tick) begin
      hx[0] <= vif.DrawX;
      hy[0] <= vif.DrawY;
      for (int i = 1; i <= PIPE_DLY; i++) begin
        hx[i] <= hx[i-1];
        hy[i] <= hy[i-1];
      end
    end
  end

  assign vif.Red_In   = ff_mode ? 8'hFF : hx[PIPE_DLY][7:0];
  assign vif.Green_In = ff_mode ? 8'hFF : hy[PIPE_DLY][7:0];
  assign vif.Blue_In  = ff_mode ? 8'hFF : (hx[PIPE_DLY][7:0] ^ hy[PIPE_DLY][7:0]);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t idle_exp();
    vec_t e;
    e.x = -1; e.y = -1; e.hs = 1'b1; e.vs = 1'b1; e.bn = 1'b0; e.rgb = 24'h0;
    return e;
  endfunction

  function automatic vec_t mk_exp(int x, int y);
    vec_t e;
    logic [7:0] r, g;
    e.x  = x;
    e.y  = y;
    e.hs = !(x >= H_VIS + H_FP && x < H_VIS + H_FP + H_SW);
    e.vs = !(y >= V_VIS + V_FP && y < V_VIS + V_FP + V_SW);
    e.bn = (x < H_VIS) && (y < V_VIS);
    r = 8'(x);
    g = 8'(y);
    e.rgb = !e.bn ? 24'h0 : (ff_mode ? 24'hFFFFFF : {r, g, r ^ g});
    return e;
  endfunction

  task automatic model_reset();
    n_clk = 0; n_tick = 0; mx = 0; my = 0;
    fs_tick = -1; hs_low = 0; vs_low = 0; vis_cnt = 0;
    line_seen = 1'b0; frame_seen = 1'b0;
    sb.delete();
    for (int i = 0; i < PIPE_DLY; i++) sb.push_back(idle_exp());
    sb.push_back(mk_exp(0, 0));
    cur = idle_exp();
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_draw_x"},  32'(vif.DrawX), 32'd0);
    chk({tag, "_draw_y"},  32'(vif.DrawY), 32'd0);
    chk({tag, "_pix_tick"}, 32'(vif.Pix_Tick), 32'd0);
    chk({tag, "_frame_start"}, 32'(vif.Frame_Start), 32'd0);
    chk({tag, "_rgb"}, 32'({vif.VGA_R, vif.VGA_G, vif.VGA_B}), 32'd0);
    chk({tag, "_hs"}, 32'(vif.VGA_HS), 32'd1);
    chk({tag, "_vs"}, 32'(vif.VGA_VS), 32'd1);
    chk({tag, "_blank_n"}, 32'(vif.VGA_BLANK_N), 32'd0);
    chk({tag, "_sync_n"}, 32'(vif.VGA_SYNC_N), 32'd0);
  endtask

  task automatic step();
    bit tick_e, fs_e;
    @(negedge Clk);
    n_clk++;
    tick_e = (n_clk % CLK_DIV) == 0;
    fs_e = 1'b0;
    if (tick_e) begin
      n_tick++;
      if (mx == H_TOT - 1) begin
        mx = 0;
        if (my == V_TOT - 1) begin
          my = 0;
          fs_e = 1'b1;
        end else begin
          my++;
        end
      end else begin
        mx++;
      end
      cur = sb.pop_front();
      sb.push_back(mk_exp(mx, my));
    end
    chk("pix_tick", 32'(vif.Pix_Tick), 32'(tick_e));
    chk("frame_start", 32'(vif.Frame_Start), 32'(fs_e));
    chk("draw_x", 32'(vif.DrawX), 32'(mx));
    chk("draw_y", 32'(vif.DrawY), 32'(my));
    chk("vga_hs", 32'(vif.VGA_HS), 32'(cur.hs));
    chk("vga_vs", 32'(vif.VGA_VS), 32'(cur.vs));
    chk("vga_blank_n", 32'(vif.VGA_BLANK_N), 32'(cur.bn));
    chk("vga_rgb", 32'({vif.VGA_R, vif.VGA_G, vif.VGA_B}), 32'(cur.rgb));
    if (tick_e) begin
      for (int i = 0; i < N_VEC; i++) begin
        if (!ff_mode && cur.x == vecs[i].x && cur.y == vecs[i].y) begin
          vec_hit[i] = 1'b1;
          chk("vec_hs", 32'(vif.VGA_HS), 32'(vecs[i].hs));
          chk("vec_vs", 32'(vif.VGA_VS), 32'(vecs[i].vs));
          chk("vec_blank_n", 32'(vif.VGA_BLANK_N), 32'(vecs[i].bn));
          chk("vec_rgb", 32'({vif.VGA_R, vif.VGA_G, vif.VGA_B}), 32'(vecs[i].rgb));
        end
      end
      if (mx == 0) begin
        if (line_seen) chk("hs_low_ticks_per_line", 32'(hs_low), 32'd6);
        hs_low = 0;
        line_seen = 1'b1;
      end
      if (fs_e) begin
        if (frame_seen) begin
          chk("vs_low_ticks_per_frame", 32'(vs_low), 32'd60);
          chk("visible_px_per_frame", 32'(vis_cnt), 32'd96);
        end
        vs_low = 0;
        vis_cnt = 0;
        frame_seen = 1'b1;
      end
      if (vif.Frame_Start === 1'b1) begin
        if (fs_tick >= 0) chk("frame_start_spacing", 32'(n_tick - fs_tick), 32'd390);
        fs_tick = n_tick;
      end
      if (vif.VGA_HS === 1'b0) hs_low++;
      if (vif.VGA_VS === 1'b0) vs_low++;
      if (vif.VGA_BLANK_N === 1'b1) vis_cnt++;
    end
  endtask

  initial begin
    // x, y -> sync/blank/rgb seen at the DAC for that coordinate (mapper B = R^G)
    vecs[0]  = '{0,  0,  1'b1, 1'b1, 1'b1, 24'h000000};
    vecs[1]  = '{15, 5,  1'b1, 1'b1, 1'b1, 24'h0F050A};
    vecs[2]  = '{7,  3,  1'b1, 1'b1, 1'b1, 24'h070304};
    vecs[3]  = '{16, 0,  1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[4]  = '{19, 2,  1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[5]  = '{20, 2,  1'b0, 1'b1, 1'b0, 24'h000000};
    vecs[6]  = '{25, 2,  1'b0, 1'b1, 1'b0, 24'h000000};
    vecs[7]  = '{26, 2,  1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[8]  = '{29, 12, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[9]  = '{3,  6,  1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[10] = '{3,  7,  1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[11] = '{3,  8,  1'b1, 1'b0, 1'b0, 24'h000000};
    vecs[12] = '{3,  9,  1'b1, 1'b0, 1'b0, 24'h000000};
    vecs[13] = '{3,  10, 1'b1, 1'b1, 1'b0, 24'h000000};
    vecs[14] = '{22, 9,  1'b0, 1'b0, 1'b0, 24'h000000};
    for (int i = 0; i < N_VEC; i++) vec_hit[i] = 1'b0;

    Reset_n = 1'b0;
    ff_mode = 1'b0;
    repeat (3) @(negedge Clk);
    check_reset_vals("por");
    model_reset();
    Reset_n = 1'b1;
    repeat (RUN_CLKS) step();

    // Async reset mid-frame, then rerun with the mapper forced to white.
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1 check_reset_vals("async");
    ff_mode = 1'b1;
    repeat (2) @(negedge Clk);
    check_reset_vals("held");
    model_reset();
    Reset_n = 1'b1;
    repeat (RUN_CLKS) step();

    for (int i = 0; i < N_VEC; i++) chk("vec_reached", 32'(vec_hit[i]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
